// File: rtl/test_value_display_pkg.sv
// Shared constants for the multiplexed hex display: digit count, the
// hex-to-segment table ({g,f,e,d,c,b,a}, active-high) and a digit-enable helper.
package test_value_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/test_value_display_hex_to_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);
  import test_value_display_pkg::*;

  assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/test_value_display.sv
// Captures a 16-bit debug value and scans it as four hex digits on a
// multiplexed 7-segment display, with optional leading-zero blanking.
module test_value_display #(
  parameter int unsigned CLK_DIV    = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] TestValue,
  input  logic        Freeze,
  input  logic        BlankLZ,
  output logic [3:0]  Anode,
  output logic [6:0]  Segment,
  output logic        Changed
);
  import test_value_display_pkg::*;

  localparam int               DIV_W      = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);
  localparam logic [3:0]       AN_OFF     = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]       SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [15:0]      capture_r;
  logic [15:0]      frame_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       idx_r;
  logic             primed_r;
  logic             digit_tick_s;
  logic [3:0]       nibble_s;
  logic             blank_s;
  logic [3:0]       an_s;
  logic [6:0]       seg_s;
  logic [6:0]       dec_seg_s;

  assign digit_tick_s = (div_r == DIV_LAST);

  // Capture register and change pulse; primed_r keeps the first post-reset load silent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      capture_r <= 16'h0000;
      primed_r  <= 1'b0;
      Changed   <= 1'b0;
    end else begin
      primed_r <= 1'b1;
      if (!Freeze) begin
        capture_r <= TestValue;
      end
      Changed <= primed_r && !Freeze && (TestValue != capture_r);
    end
  end

  // Digit divider, scan index, and frame latch taken only at the 3->0 wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_r   <= '0;
      idx_r   <= 2'd0;
      frame_r <= 16'h0000;
    end else if (digit_tick_s) begin
      div_r <= '0;
      idx_r <= idx_r + 2'd1;
      if (idx_r == LAST_DIGIT) begin
        frame_r <= capture_r;
      end
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Select the current nibble and decide leading-zero blanking for it.
  always_comb begin
    nibble_s = 4'h0;
    blank_s  = 1'b0;
    case (idx_r)
      2'd0: begin
        nibble_s = frame_r[3:0];
        blank_s  = 1'b0;
      end
      2'd1: begin
        nibble_s = frame_r[7:4];
        blank_s  = BlankLZ && (frame_r[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s = frame_r[11:8];
        blank_s  = BlankLZ && (frame_r[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s = frame_r[15:12];
        blank_s  = BlankLZ && (frame_r[15:12] == 4'h0);
      end
      default: begin
        nibble_s = 4'h0;
        blank_s  = 1'b0;
      end
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble   (nibble_s),
    .segments (dec_seg_s)
  );

  // Active-high drive for the current digit; a blanked digit keeps its anode on.
  always_comb begin
    an_s = digit_onehot(idx_r);
    if (blank_s) begin
      seg_s = 7'h00;
    end else begin
      seg_s = dec_seg_s;
    end
  end

  // Output register with polarity applied.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Anode   <= AN_OFF;
      Segment <= SEG_OFF;
    end else begin
      Anode   <= an_s ^ AN_OFF;
      Segment <= seg_s ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_test_value_display.sv
// Scoreboard bench for test_value_display with CLK_DIV=4, ACTIVE_LOW=1.
module tb_test_value_display;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] TestValue;
  logic        Freeze;
  logic        BlankLZ;
  logic [3:0]  Anode;
  logic [6:0]  Segment;
  logic        Changed;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic [10:0] sb[$];
  logic [10:0] exp_v;

  test_value_display #(.CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST(RST), .TestValue(TestValue), .Freeze(Freeze),
    .BlankLZ(BlankLZ), .Anode(Anode), .Segment(Segment), .Changed(Changed)
  );

  always #5 CLK = ~CLK;

  // Clock edges since reset release; a frame's first output follows edge 16k+1.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h5: return 7'b1101101;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hE: return 7'b1111001;  4'hF: return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected active-low {Anode,Segment} for digit d showing active-high pattern s.
  function automatic logic [10:0] lit(input int d, input logic [6:0] s);
    logic [3:0] a;
    a = 4'b0001 << d;
    return {~a, ~s};
  endfunction

  task automatic wait_frame();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (cyc % 16 == 1) found = 1'b1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL frame_sync: no frame start within 40 cycles, cyc=%0d", cyc);
    end
  endtask

  task automatic test_reset();
    int chg = 0;
    RST = 1'b1; TestValue = 16'h1234; Freeze = 1'b0; BlankLZ = 1'b0;
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({Anode, Segment, Changed} !== {4'b1111, 7'b1111111, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got %b_%b_%b want 1111_1111111_0", Anode, Segment, Changed);
    end
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({Anode, Segment, Changed} !== {4'b1110, 7'b1000000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first: got %b_%b_%b want 1110_1000000_0", Anode, Segment, Changed);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Changed !== 1'b0) chg++;
    end
    n_tests++;
    if (chg != 0) begin
      n_fail++;
      $display("FAIL reset_changed: got %0d pulses want 0", chg);
    end
  endtask

  task automatic test_scan();
    TestValue = 16'hBEEF;
    wait_frame();
    wait_frame();
    sb.push_back(lit(0, ref_seg(4'hF)));
    sb.push_back(lit(1, ref_seg(4'hE)));
    sb.push_back(lit(2, ref_seg(4'hE)));
    sb.push_back(lit(3, ref_seg(4'hB)));
    for (int d = 0; d < 4; d++) begin
      exp_v = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if ({Anode, Segment} !== exp_v) begin
          n_fail++;
          $display("FAIL scan d%0d c%0d: got %b_%b want %b_%b", d, c, Anode, Segment, exp_v[10:7], exp_v[6:0]);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_anti_tear();
    TestValue = 16'h1111;
    wait_frame();
    repeat (6) @(negedge CLK);
    TestValue = 16'h2222;
    repeat (2) @(negedge CLK);
    sb.push_back(lit(2, ref_seg(4'h1)));
    sb.push_back(lit(3, ref_seg(4'h1)));
    for (int d = 0; d < 4; d++) sb.push_back(lit(d, ref_seg(4'h2)));
    for (int d = 0; d < 6; d++) begin
      exp_v = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if ({Anode, Segment} !== exp_v) begin
          n_fail++;
          $display("FAIL anti_tear s%0d c%0d: got %b_%b want %b_%b", d, c, Anode, Segment, exp_v[10:7], exp_v[6:0]);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_freeze();
    int chg = 0;
    Freeze = 1'b1;
    TestValue = 16'h00A0;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++) sb.push_back(lit(d, ref_seg(4'h2)));
    for (int d = 0; d < 8; d++) begin
      exp_v = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if ({Anode, Segment, Changed} !== {exp_v, 1'b0}) begin
          n_fail++;
          $display("FAIL freeze_hold s%0d c%0d: got %b_%b_%b want %b_%b_0", d, c, Anode, Segment, Changed, exp_v[10:7], exp_v[6:0]);
        end
        @(negedge CLK);
      end
    end
    Freeze = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (Changed !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_release_pulse: got %b want 1", Changed);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Changed !== 1'b0) chg++;
    end
    n_tests++;
    if (chg != 0) begin
      n_fail++;
      $display("FAIL freeze_single_pulse: got %0d extra pulses want 0", chg);
    end
    wait_frame();
    sb.push_back(lit(0, ref_seg(4'h0)));
    sb.push_back(lit(1, ref_seg(4'hA)));
    sb.push_back(lit(2, ref_seg(4'h0)));
    sb.push_back(lit(3, ref_seg(4'h0)));
    for (int d = 0; d < 4; d++) begin
      exp_v = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if ({Anode, Segment} !== exp_v) begin
          n_fail++;
          $display("FAIL freeze_new d%0d c%0d: got %b_%b want %b_%b", d, c, Anode, Segment, exp_v[10:7], exp_v[6:0]);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0100};
    BlankLZ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      TestValue = vals[k];
      wait_frame();
      case (k)
        0: begin
          sb.push_back(lit(0, ref_seg(4'h5)));
          for (int d = 1; d < 4; d++) sb.push_back(lit(d, 7'h00));
        end
        1: begin
          sb.push_back(lit(0, ref_seg(4'h0)));
          for (int d = 1; d < 4; d++) sb.push_back(lit(d, 7'h00));
        end
        default: begin
          sb.push_back(lit(0, ref_seg(4'h0)));
          sb.push_back(lit(1, ref_seg(4'h0)));
          sb.push_back(lit(2, ref_seg(4'h1)));
          sb.push_back(lit(3, 7'h00));
        end
      endcase
      for (int d = 0; d < 4; d++) begin
        exp_v = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
          n_tests++;
          if ({Anode, Segment} !== exp_v) begin
            n_fail++;
            $display("FAIL blank v%h d%0d c%0d: got %b_%b want %b_%b", vals[k], d, c, Anode, Segment, exp_v[10:7], exp_v[6:0]);
          end
          @(negedge CLK);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (6) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if ({Anode, Segment, Changed} !== {4'b1111, 7'b1111111, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %b_%b_%b want 1111_1111111_0", Anode, Segment, Changed);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({Anode, Segment, Changed} !== {4'b1110, 7'b1000000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_restart: got %b_%b_%b want 1110_1000000_0", Anode, Segment, Changed);
    end
    repeat (3) @(negedge CLK);
    n_tests++;
    if (Anode !== 4'b1110) begin
      n_fail++;
      $display("FAIL async_digit0_hold: got %b want 1110", Anode);
    end
    @(negedge CLK);
    n_tests++;
    if (Anode !== 4'b1101) begin
      n_fail++;
      $display("FAIL async_digit1_start: got %b want 1101", Anode);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_anti_tear();
    test_freeze();
    test_blank();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
